// File: rtl/clock_time_setter.sv
// Sequencer for the alarm clock's set interface: computes how many advance pulses
// each field needs to reach a target value and drives them minutes, hours, then day.
module clock_time_setter #(
  parameter int unsigned NS = 60,
  parameter int unsigned NH = 24,
  parameter int unsigned NW = 7
) (
  input  logic                  Pulse,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic                  Mode,
  input  logic [$clog2(NS)-1:0] TgtMin,
  input  logic [$clog2(NH)-1:0] TgtHrs,
  input  logic [$clog2(NW)-1:0] TgtDay,
  input  logic [$clog2(NS)-1:0] CurMin,
  input  logic [$clog2(NH)-1:0] CurHrs,
  input  logic [$clog2(NW)-1:0] CurDay,
  output logic                  Timeset,
  output logic                  Alarmset,
  output logic                  Minadv,
  output logic                  Hrsadv,
  output logic                  Dayadv,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
);

  localparam int unsigned WM = $clog2(NS);
  localparam int unsigned WH = $clog2(NH);
  localparam int unsigned WD = $clog2(NW);
  localparam int unsigned WMH = (WM > WH) ? WM : WH;
  localparam int unsigned CW = (WMH > WD) ? WMH : WD;

  localparam logic [WM:0] NsExt = (WM + 1)'(NS);
  localparam logic [WH:0] NhExt = (WH + 1)'(NH);
  localparam logic [WD:0] NwExt = (WD + 1)'(NW);

  typedef enum logic [2:0] {
    StIdle, StSetup, StMin, StHrs, StDay, StHold, StDone
  } state_e;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [WM-1:0] dm_q, dm_d;
  logic [WH-1:0] dh_q, dh_d;
  logic [WD-1:0] dd_q, dd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_d;

  logic [WM:0]   dm_w;
  logic [WH:0]   dh_w;
  logic [WD:0]   dd_w;
  logic          req_bad;

  state_e        after_min_st, after_hrs_st, after_day_st;
  logic [CW-1:0] after_min_cnt, after_hrs_cnt, after_day_cnt;

  logic          set_on;
  logic          timeset_d, alarmset_d, minadv_d, hrsadv_d, dayadv_d, busy_d, done_d;

  // Modular differences one bit wider than the field; a set top bit means negative.
  always_comb begin
    dm_w = {1'b0, TgtMin} - {1'b0, CurMin};
    if (dm_w[WM]) dm_w = dm_w + NsExt;
    dh_w = {1'b0, TgtHrs} - {1'b0, CurHrs};
    if (dh_w[WH]) dh_w = dh_w + NhExt;
    dd_w = {1'b0, TgtDay} - {1'b0, CurDay};
    if (dd_w[WD]) dd_w = dd_w + NwExt;
    if (Mode) dd_w = '0;
    req_bad = ({1'b0, TgtMin} >= NsExt) || ({1'b0, TgtHrs} >= NhExt) ||
              (!Mode && ({1'b0, TgtDay} >= NwExt));
  end

  // First phase with a non-zero count at or after each point; zero phases cost no cycle.
  always_comb begin
    if (dd_q != '0) begin
      after_day_st  = StDay;
      after_day_cnt = CW'(dd_q);
    end else begin
      after_day_st  = StHold;
      after_day_cnt = '0;
    end
    if (dh_q != '0) begin
      after_hrs_st  = StHrs;
      after_hrs_cnt = CW'(dh_q);
    end else begin
      after_hrs_st  = after_day_st;
      after_hrs_cnt = after_day_cnt;
    end
    if (dm_q != '0) begin
      after_min_st  = StMin;
      after_min_cnt = CW'(dm_q);
    end else begin
      after_min_st  = after_hrs_st;
      after_min_cnt = after_hrs_cnt;
    end
  end

  always_ff @(posedge Pulse or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      dm_q    <= '0;
      dh_q    <= '0;
      dd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dm_q    <= dm_d;
      dh_q    <= dh_d;
      dd_q    <= dd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dm_d    = dm_q;
    dh_d    = dh_q;
    dd_d    = dd_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = StSetup;
            mode_d  = Mode;
            dm_d    = dm_w[WM-1:0];
            dh_d    = dh_w[WH-1:0];
            dd_d    = dd_w[WD-1:0];
          end
        end
      end
      StSetup: begin
        state_d = after_min_st;
        cnt_d   = after_min_cnt;
      end
      StMin: begin
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = after_hrs_st;
          cnt_d   = after_hrs_cnt;
        end
      end
      StHrs: begin
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = after_day_st;
          cnt_d   = after_day_cnt;
        end
      end
      StDay: begin
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode the upcoming state so that every output is a flop.
  always_comb begin
    set_on     = (state_d == StSetup) || (state_d == StMin) || (state_d == StHrs) ||
                 (state_d == StDay) || (state_d == StHold);
    timeset_d  = set_on && !mode_d;
    alarmset_d = set_on && mode_d;
    minadv_d   = (state_d == StMin);
    hrsadv_d   = (state_d == StHrs);
    dayadv_d   = (state_d == StDay);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge Pulse or negedge Reset_n) begin
    if (!Reset_n) begin
      Timeset  <= 1'b0;
      Alarmset <= 1'b0;
      Minadv   <= 1'b0;
      Hrsadv   <= 1'b0;
      Dayadv   <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      Timeset  <= timeset_d;
      Alarmset <= alarmset_d;
      Minadv   <= minadv_d;
      Hrsadv   <= hrsadv_d;
      Dayadv   <= dayadv_d;
      Busy     <= busy_d;
      Done     <= done_d;
      Err      <= err_d;
    end
  end

endmodule

// File: tb/tb_clock_time_setter.sv
// Scoreboard bench for clock_time_setter: the driver queues hand-computed pulse counts
// and end cycles; the monitor tallies DUT outputs and checks them on each Done/Err.
module tb_clock_time_setter;

  logic       Pulse = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic       Mode = 1'b0;
  logic [5:0] TgtMin = '0, CurMin = '0;
  logic [4:0] TgtHrs = '0, CurHrs = '0;
  logic [2:0] TgtDay = '0, CurDay = '0;
  logic       Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Busy, Done, Err;

  clock_time_setter #(.NS(60), .NH(24), .NW(7)) dut (
    .Pulse    (Pulse),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Mode     (Mode),
    .TgtMin   (TgtMin),
    .TgtHrs   (TgtHrs),
    .TgtDay   (TgtDay),
    .CurMin   (CurMin),
    .CurHrs   (CurHrs),
    .CurDay   (CurDay),
    .Timeset  (Timeset),
    .Alarmset (Alarmset),
    .Minadv   (Minadv),
    .Hrsadv   (Hrsadv),
    .Dayadv   (Dayadv),
    .Busy     (Busy),
    .Done     (Done),
    .Err      (Err)
  );

  always #5 Pulse = ~Pulse;

  int cyc = 0;
  always @(posedge Pulse) cyc <= cyc + 1;

  typedef struct {
    bit err;
    bit mode;
    int nmin;
    int nhrs;
    int nday;
    int nset;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   napplied = 0;
  int   nfail = 0;
  bit   abort = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    napplied++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One request; counts are hand-computed. End cycle is the accept edge + 2 + total advances.
  task automatic issue(input bit md, input int cm, input int ch, input int cd, input int tm,
                       input int th, input int td, input bit is_err, input int nm,
                       input int nh, input int nd);
    exp_t e;
    int   k;
    @(negedge Pulse);
    Mode   = md;
    CurMin = 6'(cm);
    CurHrs = 5'(ch);
    CurDay = 3'(cd);
    TgtMin = 6'(tm);
    TgtHrs = 5'(th);
    TgtDay = 3'(td);
    Start  = 1'b1;
    @(posedge Pulse);
    #1;
    k      = cyc;
    e.err  = is_err;
    e.mode = md;
    e.nmin = nm;
    e.nhrs = nh;
    e.nday = nd;
    e.nset = is_err ? 0 : 2 + nm + nh + nd;
    e.at   = is_err ? k : k + 2 + nm + nh + nd;
    exp_q.push_back(e);
    @(negedge Pulse);
    Start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge Pulse);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("timeout_pending", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge Pulse);
  endtask

  int a_min = 0, a_hrs = 0, a_day = 0, a_ts = 0, a_as = 0, a_viol = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge Pulse);
      if (abort) begin
        a_min = 0; a_hrs = 0; a_day = 0; a_ts = 0; a_as = 0; a_viol = 0;
        abort = 1'b0;
      end else if (Reset_n) begin
        a_min += int'(Minadv);
        a_hrs += int'(Hrsadv);
        a_day += int'(Dayadv);
        a_ts  += int'(Timeset);
        a_as  += int'(Alarmset);
        if ((int'(Minadv) + int'(Hrsadv) + int'(Dayadv)) > 1) a_viol++;
        if (Timeset && Alarmset) a_viol++;
        if (Err && (Done || Busy)) a_viol++;
        if ((Timeset || Alarmset || Minadv || Hrsadv || Dayadv) && !Busy) a_viol++;
        if (Done || Err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_end", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("kind_err", int'(Err), int'(e.err));
            chk("end_cycle", cyc, e.at);
            chk("minadv_cycles", a_min, e.nmin);
            chk("hrsadv_cycles", a_hrs, e.nhrs);
            chk("dayadv_cycles", a_day, e.nday);
            chk("set_line_cycles", e.mode ? a_as : a_ts, e.nset);
            chk("other_set_line", e.mode ? a_ts : a_as, 0);
            chk("invariants", a_viol, 0);
          end
          a_min = 0; a_hrs = 0; a_day = 0; a_ts = 0; a_as = 0; a_viol = 0;
        end
      end
    end
  end

  initial begin
    #12;
    chk("reset_outputs", int'({Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Busy, Done, Err}), 0);
    @(negedge Pulse);
    Reset_n = 1'b1;
    repeat (2) @(negedge Pulse);

    // Basic set-time: 55 min, 7 hrs, 4 days.
    issue(1'b0, 0, 0, 0, 55, 7, 4, 1'b0, 55, 7, 4);
    wait_idle();
    // Alarm: day target ignored.
    issue(1'b1, 0, 0, 0, 1, 8, 6, 1'b0, 1, 8, 0);
    wait_idle();
    // Wrap-around in every field.
    issue(1'b0, 58, 23, 6, 2, 0, 0, 1'b0, 4, 1, 1);
    wait_idle();
    // Target equals present value.
    issue(1'b0, 17, 9, 3, 17, 9, 3, 1'b0, 0, 0, 0);
    wait_idle();
    // Largest legal targets from zero.
    issue(1'b0, 0, 0, 0, 59, 23, 6, 1'b0, 59, 23, 6);
    wait_idle();
    // Rejections.
    issue(1'b0, 0, 0, 0, 60, 0, 0, 1'b1, 0, 0, 0);
    wait_idle();
    issue(1'b1, 0, 0, 0, 0, 24, 0, 1'b1, 0, 0, 0);
    wait_idle();
    issue(1'b0, 0, 0, 0, 0, 0, 7, 1'b1, 0, 0, 0);
    wait_idle();
    // Day 7 is ignored in alarm mode and must not be rejected.
    issue(1'b1, 5, 5, 0, 5, 5, 7, 1'b0, 0, 0, 0);
    wait_idle();

    // Start and changed inputs while busy must not disturb the running sequence.
    issue(1'b0, 10, 3, 2, 20, 5, 1, 1'b0, 10, 2, 6);
    repeat (4) @(negedge Pulse);
    Mode   = 1'b1;
    TgtMin = 6'd0;
    CurMin = 6'd30;
    TgtHrs = 5'd12;
    Start  = 1'b1;
    repeat (3) @(negedge Pulse);
    Start = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of the minute phase.
    issue(1'b0, 0, 0, 0, 55, 7, 4, 1'b0, 55, 7, 4);
    repeat (10) @(posedge Pulse);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        int'({Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Busy, Done, Err}), 0);
    Reset_n = 1'b1;
    exp_q.delete();
    abort = 1'b1;
    @(negedge Pulse);
    chk("idle_after_reset", int'(Busy), 0);
    repeat (3) @(negedge Pulse);
    chk("still_idle", int'({Busy, Timeset, Minadv}), 0);
    issue(1'b1, 30, 12, 0, 29, 11, 0, 1'b0, 59, 23, 0);
    wait_idle();
    issue(1'b0, 0, 0, 0, 55, 7, 4, 1'b0, 55, 7, 4);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", napplied, nfail);
    $finish;
  end

endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
- Automatic initiator for the alarm clock's set interface (Timeset/Alarmset plus Minadv/Hrsadv/Dayadv).
- Given a target day/hour/minute and the clock's present values, it drives exactly the number of advance cycles needed, in the order minutes, hours, day.
- It replaces manual button sequencing in system benches and in the front-panel controller.
- It sits between the user/host logic and top_level's set inputs, clocked by the same Pulse.

Parameters:
- NS, 60, minutes per hour (minute modulus)
- NH, 24, hours per day (hour modulus)
- NW, 7, days per week (day modulus)

Ports:
- Pulse  input  1  system clock; all state changes on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Start  input  1  request; sampled only in IDLE
- Mode  input  1  0 = set time (drives Timeset), 1 = set alarm (drives Alarmset)
- TgtMin  input  $clog2(NS)  target minute
- TgtHrs  input  $clog2(NH)  target hour
- TgtDay  input  $clog2(NW)  target day; ignored when Mode=1
- CurMin  input  $clog2(NS)  present minute of the register being set
- CurHrs  input  $clog2(NH)  present hour
- CurDay  input  $clog2(NW)  present day
- Timeset  output  1  to top_level
- Alarmset  output  1  to top_level
- Minadv  output  1  to top_level
- Hrsadv  output  1  to top_level
- Dayadv  output  1  to top_level
- Busy  output  1  high in every state except IDLE
- Done  output  1  one-cycle completion pulse
- Err  output  1  one-cycle pulse: request rejected

Behaviour:
- All outputs are registered. Reset_n low forces all outputs to 0 and the FSM to IDLE immediately (asynchronous), including mid-sequence.
- The set line dropping on reset is acceptable: partial advances already applied stay in the clock.
- Each advance line held high for one Pulse cycle advances the target field by exactly 1. Set-mode advances do not carry into the next field.
- Start sampled in IDLE:
  - If TgtMin>=NS, TgtHrs>=NH, or (Mode=0 and TgtDay>=NW): pulse Err for 1 cycle, stay IDLE, drive no set lines.
  - Otherwise latch Mode and compute counts:
    - dm = (TgtMin-CurMin) mod NS
    - dh = (TgtHrs-CurHrs) mod NH
    - dd = (TgtDay-CurDay) mod NW, forced to 0 when Mode=1
  - Arithmetic is done one bit wider than the field; add the modulus when the difference is negative.
- States:
  - IDLE
  - SETUP (1 cycle): selected set line high, no advance
  - MIN (dm cycles): Minadv high
  - HRS (dh cycles): Hrsadv high
  - DAY (dd cycles): Dayadv high
  - HOLD (1 cycle): set line high, all advances low
  - DONE (1 cycle): set line low, Done=1, then IDLE
- Phases with a count of 0 are skipped with no dead cycle. The selected set line stays high continuously from SETUP through HOLD.
- Latency: with Start sampled at edge k, Done is high in cycle k+3+dm+dh+dd.
- Start while Busy is ignored (no queueing). Cur*/Tgt* are used only at the accept edge; later changes have no effect.
- Only one advance line is high in any cycle. Timeset and Alarmset are never high together.
- Err and Done are never high together.

Test Plan:
- Reset, Mode=0, Cur=0/0/0, Tgt=Min55 Hrs7 Day4, Start at edge k:
  - Timeset high k+1..k+68
  - Minadv high exactly 55 cycles (k+2..k+56)
  - Hrsadv 7 cycles, Dayadv 4 cycles
  - Done at k+69
  - Connected top_level then displays 4/07:55.
- Mode=1, Cur=0:00, Tgt=08:01, TgtDay=6:
  - Alarmset only, Minadv 1 cycle, Hrsadv 8 cycles, Dayadv never
  - Done at k+12
  - Alarm display reads 0801.
- Wrap-around: CurMin=58, TgtMin=2, CurHrs=23, TgtHrs=0, CurDay=6, TgtDay=0.
  - Expect Minadv 4, Hrsadv 1, Dayadv 1 cycles; Done at k+9.
- Tgt equals Cur: no advance pulses, Timeset high 2 cycles, Done at k+3.
- Rejection and busy handling:
  - TgtMin=60: Err pulse 1 cycle, no set lines, Busy stays 0.
  - Start re-asserted while Busy: no effect on counts or Done timing.
- Reset_n low for 1 ns during MIN phase: all outputs 0 at once.
  - After release, FSM is IDLE.
  - A new Start runs a full correct sequence.
